// File: rtl/camera_ray_gen.sv
// Camera ray generator: walks an IMG_W x IMG_H image in raster order and emits the
// per-pixel reciprocal ray direction. Define CAMERA_RAY_GEN_STALL_CNT_EN for the stall counter.

`ifndef INFINITY_24
`define INFINITY_24 24'h7FFFFF
`endif
`ifndef NEGATIVE_INFINITY_24
`define NEGATIVE_INFINITY_24 24'h800000
`endif

package camera_ray_gen_pkg;
    typedef struct packed {
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
    } vec3_t;
endpackage

module camera_ray_gen
    import camera_ray_gen_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter logic [23:0] FOCAL = 24'h004000
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        start,
    input  logic        ray_ready,
    output logic        ray_valid,
    output vec3_t       ray_orig,
    output vec3_t       inv_ray_dir,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        busy,
    output logic        done,
    output logic [31:0] stall_cnt
);

    typedef enum logic [2:0] {IDLE, DIV_Z, DIV_X, DIV_Y, EMIT} state_e;

    localparam logic [4:0] LAST_STEP = 5'd24;
    localparam logic [7:0] LAST_X    = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_Y    = 8'(IMG_H - 1);
    localparam logic [9:0] HALF_W    = 10'(IMG_W / 2);
    localparam logic [9:0] HALF_H    = 10'(IMG_H / 2);

    state_e      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [23:0] rem_q;
    logic [23:0] quot_q;
    logic [23:0] inv_x_q, inv_y_q, inv_z_q;
    logic [7:0]  pix_x_q, pix_y_q;
    logic        done_q;

    logic        in_div, last_step, accept, accept_last, frame_start;
    logic [9:0]  off_x, off_y;
    logic [23:0] dir_x, dir_y, den_raw, den_mag;
    logic        den_neg, den_zero;
    logic        first_step, ge;
    logic [23:0] rem_cur, quot_cur, rem_nxt;
    logic [24:0] trial, quot_nxt;
    logic [23:0] result;

    // Reciprocal of |d| with the sign restored and out-of-range quotients clamped.
    function automatic logic [23:0] recip_result(input logic [24:0] q, input logic neg,
                                                 input logic zero);
        if (zero)
            return `INFINITY_24;
        if (q > 25'h07F_FFFF)
            return neg ? `NEGATIVE_INFINITY_24 : `INFINITY_24;
        return neg ? 24'(-q[23:0]) : q[23:0];
    endfunction

    assign in_div      = (state_q == DIV_Z) || (state_q == DIV_X) || (state_q == DIV_Y);
    assign last_step   = (step_q == LAST_STEP);
    assign accept      = (state_q == EMIT) && ray_ready;
    assign accept_last = accept && (pix_x_q == LAST_X) && (pix_y_q == LAST_Y);
    assign frame_start = (state_q == IDLE) && start;

    // Pixel offset from the image centre, scaled to Q12.12.
    assign off_x = {2'b00, pix_x_q} - HALF_W;
    assign off_y = {2'b00, pix_y_q} - HALF_H;
    assign dir_x = {{2{off_x[9]}}, off_x, 12'h000};
    assign dir_y = {{2{off_y[9]}}, off_y, 12'h000};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        den_raw = FOCAL;
        case (state_q)
            DIV_X:   den_raw = dir_x;
            DIV_Y:   den_raw = dir_y;
            default: den_raw = FOCAL;
        endcase
    end

    assign den_neg  = den_raw[23];
    assign den_mag  = den_neg ? 24'(-den_raw) : den_raw;
    assign den_zero = (den_mag == 24'd0);

    // Restoring division of the constant 2^24: its only set bit enters on the first step.
    assign first_step = (step_q == 5'd0);
    assign rem_cur    = first_step ? 24'd0 : rem_q;
    assign quot_cur   = first_step ? 24'd0 : quot_q;
    assign trial      = {rem_cur, first_step};
    assign ge         = (trial >= {1'b0, den_mag});
    assign rem_nxt    = ge ? 24'(trial - {1'b0, den_mag}) : trial[23:0];
    assign quot_nxt   = {quot_cur, ge};
    assign result     = recip_result(quot_nxt, den_neg, den_zero);

    assign step_d = (in_div && !last_step) ? step_q + 5'd1 : 5'd0;

    always_ff @(posedge sysclk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = DIV_Z;
            DIV_Z:   if (last_step) state_d = DIV_X;
            DIV_X:   if (last_step) state_d = DIV_Y;
            DIV_Y:   if (last_step) state_d = EMIT;
            EMIT:    if (accept)    state_d = accept_last ? IDLE : DIV_X;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ray_valid = (state_q == EMIT);
        busy      = (state_q != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            step_q  <= 5'd0;
            rem_q   <= 24'd0;
            quot_q  <= 24'd0;
            inv_x_q <= 24'd0;
            inv_y_q <= 24'd0;
            inv_z_q <= 24'd0;
            pix_x_q <= 8'd0;
            pix_y_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            done_q <= accept_last;
            if (in_div) begin
                rem_q  <= rem_nxt;
                quot_q <= quot_nxt[23:0];
                if (last_step) begin
                    case (state_q)
                        DIV_Z:   inv_z_q <= result;
                        DIV_X:   inv_x_q <= result;
                        default: inv_y_q <= result;
                    endcase
                end
            end
            if (frame_start) begin
                pix_x_q <= 8'd0;
                pix_y_q <= 8'd0;
            end else if (accept) begin
                if (pix_x_q == LAST_X) begin
                    pix_x_q <= 8'd0;
                    pix_y_q <= (pix_y_q == LAST_Y) ? 8'd0 : pix_y_q + 8'd1;
                end else begin
                    pix_x_q <= pix_x_q + 8'd1;
                end
            end
        end
    end

`ifdef CAMERA_RAY_GEN_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge sysclk) begin
        if (rst || frame_start)
            stall_q <= 32'd0;
        else if (ray_valid && !ray_ready && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

    assign ray_orig    = '0;
    assign inv_ray_dir = '{x: inv_x_q, y: inv_y_q, z: inv_z_q};
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign done        = done_q;

endmodule

// File: doc/camera_ray_gen.md
CAMERA_RAY_GEN -- requirements
Module: camera_ray_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (even, 2..256).
REQ-002 SHALL have parameter IMG_H, default 8, image height in pixels (even, 2..256).
REQ-003 SHALL have parameter FOCAL, default 24'h004000, camera z-direction in raw Q12.12 (4.0), positive.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port list, clock and reset first:
 sysclk  in  1  clock
 rst  in  1  synchronous active-high reset
 start  in  1  one-cycle pulse that begins a frame
 ray_ready  in  1  downstream ray_bbox_intersect ready
 ray_valid  out  1  ray_orig/inv_ray_dir/pix_* valid
 ray_orig  out  vec3  ray origin, always '{0,0,0}
 inv_ray_dir  out  vec3  per-component reciprocal of ray direction, Q12.12 signed 24-bit
 pix_x  out  8  pixel column of current ray
 pix_y  out  8  pixel row of current ray
 busy  out  1  frame in progress
 done  out  1  one-cycle pulse, frame complete
 stall_cnt  out  32  backpressure cycle count

Function
REQ-006 Direction for pixel (px,py): d.x = (px - IMG_W/2)*4096, d.y = (py - IMG_H/2)*4096, d.z = FOCAL, all raw Q12.12.
REQ-007 Each inv component SHALL equal 2^24 / |d| truncated toward zero, negated when d < 0.
REQ-008 d == 0 SHALL yield `INFINITY_24; quotient > 24'h7FFFFF SHALL saturate to `INFINITY_24 (d > 0) or `NEGATIVE_INFINITY_24 (d < 0).
REQ-009 One shared restoring divider SHALL compute each component in exactly 25 cycles.
REQ-010 FSM states: IDLE, DIV_Z, DIV_X, DIV_Y, EMIT.
REQ-011 IDLE -> DIV_Z on start; DIV_Z -> DIV_X after 25 cycles; DIV_X -> DIV_Y after 25; DIV_Y -> EMIT after 25.
REQ-012 inv_z SHALL be computed once per frame (DIV_Z); DIV_X and DIV_Y SHALL run for every pixel.
REQ-013 With start at cycle 0, ray_valid SHALL first assert at cycle 76.
REQ-014 ray_valid is high only in EMIT; all ray outputs SHALL stay stable while ray_valid && !ray_ready.
REQ-015 A ray is accepted on a cycle with ray_valid && ray_ready; EMIT -> DIV_X for the next pixel; the next ray_valid SHALL assert exactly 51 cycles after acceptance.
REQ-016 Raster order: pix_x increments fastest and wraps to 0 at IMG_W with pix_y increment.
REQ-017 After acceptance of pixel (IMG_W-1, IMG_H-1), SHALL return to IDLE and pulse done on the following cycle; busy deasserts the same cycle done pulses.
REQ-018 busy SHALL be high from the cycle after start through the final acceptance.
REQ-019 start while busy SHALL be ignored; start coincident with the done pulse SHALL begin a new frame.

Reset
REQ-020 rst SHALL force IDLE, ray_valid=0, inv_ray_dir=0, pix_x=pix_y=0, busy=0, done=0, stall_cnt=0 on the next edge.
REQ-021 rst mid-frame SHALL abort the frame with no done pulse; rst dominates start in the same cycle.

Configuration
REQ-022 Macro CAMERA_RAY_GEN_STALL_CNT_EN: when defined, stall_cnt SHALL increment (saturating at 32'hFFFFFFFF) each cycle with ray_valid && !ray_ready, clear on start and rst.
REQ-023 When CAMERA_RAY_GEN_STALL_CNT_EN is undefined, stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-024 IMG_W=4, IMG_H=2, FOCAL=24'h004000, ray_ready=1, start at cycle 0 -> first ray at cycle 76, pix(0,0), inv=(24'hFFF800, 24'hFFF000, 24'h000400); 8 rays total; done one cycle after 8th acceptance.
REQ-025 Same config, pixel (2,1) -> inv.x=`INFINITY_24, inv.y=`INFINITY_24, inv.z=24'h000400.
REQ-026 ray_ready low for 10 cycles on first ray -> outputs unchanged for all 10 cycles; stall_cnt=10 with CAMERA_RAY_GEN_STALL_CNT_EN, 0 without.
REQ-027 FOCAL=24'h000001 -> inv.z=`INFINITY_24 on every ray.
REQ-028 rst pulsed at cycle 60 of a frame -> ray_valid=0, busy=0 next cycle, no done; new start -> first ray again pix(0,0) 76 cycles later.
REQ-029 start pulsed at cycle 30 of an active frame -> no effect; ray count and timing identical to REQ-024.
